// File: rtl/kernel_host_pkg.sv
// Shared types and defaults for the kernel host driver.
package kernel_host_pkg;

  localparam int unsigned DATA_W_DEF  = 64;
  localparam int unsigned DEPTH_DEF   = 1;
  localparam int unsigned TIMEOUT_DEF = 1024;
  localparam int unsigned TO_CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    READ,
    RESP
  } state_e;

endpackage

// File: rtl/kernel_host_driver.sv
// Host-side sequencer: optional array preload, kernel start, wait for done (bounded),
// array readback, and a held valid/ready response.
module kernel_host_driver
  import kernel_host_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned ADDR_W  = 1,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_W-1:0]       cmd_init,
  input  logic                    cmd_load,
  input  logic [DEPTH*DATA_W-1:0] cmd_arr,
  output logic                    k_r_enable,
  output logic [DATA_W-1:0]       k_init_i,
  output logic                    k_controlArr,
  output logic                    k_arrWEnable,
  output logic [ADDR_W-1:0]       k_arrAddr,
  output logic [DATA_W-1:0]       k_arrWData,
  input  logic [DATA_W-1:0]       k_arrRData,
  input  logic                    k_w_enable,
  input  logic [DATA_W-1:0]       k_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_result,
  output logic [DEPTH*DATA_W-1:0] rsp_arr,
  output logic                    rsp_timeout
);

  localparam int unsigned IDX_W = $clog2(DEPTH + 2);
  localparam int unsigned ARR_W = DEPTH * DATA_W;

  state_e                state, state_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [TO_CNT_W-1:0]   wait_cnt, wait_cnt_d;
  logic [ARR_W-1:0]      arr_q;
  logic [ARR_W-1:0]      arr_src;
  logic                  accept, done_hit, to_hit;

  logic                  cmd_ready_d, rsp_valid_d, k_r_enable_d;
  logic                  k_controlArr_d, k_arrWEnable_d;
  logic [ADDR_W-1:0]     k_arrAddr_d;
  logic [DATA_W-1:0]     k_arrWData_d;

  // Next state plus next values of the registered kernel/handshake outputs
  always_comb begin
    state_d        = state;
    idx_d          = idx;
    wait_cnt_d     = wait_cnt;
    accept         = 1'b0;
    done_hit       = 1'b0;
    to_hit         = 1'b0;
    cmd_ready_d    = 1'b0;
    rsp_valid_d    = 1'b0;
    k_r_enable_d   = 1'b0;
    k_controlArr_d = 1'b1;
    k_arrWEnable_d = 1'b0;
    k_arrAddr_d    = '0;
    k_arrWData_d   = '0;
    arr_src        = (state == IDLE) ? cmd_arr : arr_q;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = cmd_load ? LOAD : START;
        end
      end
      LOAD: begin
        if (idx == IDX_W'(DEPTH - 1)) begin
          idx_d   = '0;
          state_d = START;
        end else begin
          idx_d = idx + IDX_W'(1);
        end
      end
      START: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (k_w_enable) begin
          done_hit = 1'b1;
          idx_d    = '0;
          state_d  = READ;
        end else if (wait_cnt == TO_CNT_W'(TIMEOUT - 1)) begin
          to_hit  = 1'b1;
          idx_d   = '0;
          state_d = READ;
        end else begin
          wait_cnt_d = wait_cnt + TO_CNT_W'(1);
        end
      end
      READ: begin
        if (idx == IDX_W'(DEPTH)) begin
          idx_d   = '0;
          state_d = RESP;
        end else begin
          idx_d = idx + IDX_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d    = (state_d == IDLE);
    rsp_valid_d    = (state_d == RESP);
    k_r_enable_d   = (state_d == START);
    k_controlArr_d = !((state_d == START) || (state_d == WAIT));
    k_arrWEnable_d = (state_d == LOAD);

    // Readback issues addresses 0..DEPTH-1; the final READ cycle only captures
    if ((state_d == LOAD) || ((state_d == READ) && (idx_d < IDX_W'(DEPTH))))
      k_arrAddr_d = ADDR_W'(idx_d);

    if (state_d == LOAD) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (idx_d == IDX_W'(i)) k_arrWData_d = arr_src[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      wait_cnt     <= '0;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      k_r_enable   <= 1'b0;
      k_controlArr <= 1'b1;
      k_arrWEnable <= 1'b0;
      k_arrAddr    <= '0;
      k_arrWData   <= '0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      wait_cnt     <= wait_cnt_d;
      cmd_ready    <= cmd_ready_d;
      rsp_valid    <= rsp_valid_d;
      k_r_enable   <= k_r_enable_d;
      k_controlArr <= k_controlArr_d;
      k_arrWEnable <= k_arrWEnable_d;
      k_arrAddr    <= k_arrAddr_d;
      k_arrWData   <= k_arrWData_d;
    end
  end

  // Command latch, result capture and readback capture (read data lags address by one cycle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_init_i    <= '0;
      arr_q       <= '0;
      rsp_result  <= '0;
      rsp_arr     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        k_init_i    <= cmd_init;
        arr_q       <= cmd_arr;
        rsp_timeout <= 1'b0;
      end
      if (done_hit) begin
        rsp_result  <= k_result;
        rsp_timeout <= 1'b0;
      end else if (to_hit) begin
        rsp_result  <= '0;
        rsp_timeout <= 1'b1;
      end
      if (state == READ) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (idx == IDX_W'(i + 1)) rsp_arr[i*DATA_W +: DATA_W] <= k_arrRData;
        end
      end
    end
  end

endmodule
